inst_fetch_decode: RTL and testbench
====================================

// Module: inst_fetch_decode
// PURPOSE
//  Consumer side of the 8-bit instruction ROM: owns the PC, drives the ROM address,
//  registers each returned byte, decodes it into op/register/immediate fields for the
//  datapath, and resolves forward/backward branches and halt. 2 stages: IF (PC->ROM) and ID (IR->decode).
// PARAMETERS
//  RESET_PC  8'd0  PC loaded at reset (start_addr_i overrides on start)
// PORTS
//  clk_i         in   1  clock, rising edge
//  rst_n_i       in   1  asynchronous reset, active-low
//  start_i       in   1  begin fetching at start_addr_i (accepted in IDLE/HALTED only)
//  start_addr_i  in   8  program entry point (e.g. 0, 93, 138)
//  stall_i       in   1  datapath busy: hold PC, IR and all state
//  rom_addr_o    out  8  ROM address (= PC)
//  rom_data_i    in   8  ROM instruction byte, combinational from rom_addr_o
//  flag_i        in   1  datapath condition flag (seq/slt result)
//  reg_val_i     in   8  datapath value of register rs_o (read combinationally)
//  inst_valid_o  out  1  decode outputs valid this cycle
//  pc_id_o       out  8  address of instruction in ID
//  op_o          out  4  AND0 ADD1 SLT2 HALT3 LOAD4 STORE5 ABS6 SEQ7 BRB8 SET9 SLL10 SRL11 BR12 SUB13 ILL15
//  rd_o / rs_o   out  3  destination / source register
//  imm_o         out  5  SET immediate, zero otherwise
//  halted_o      out  1  high in HALTED state
// BEHAVIOUR
//  Reset (async): state=IDLE, PC=RESET_PC, IR=0, ir_valid=0; all outputs 0 except rom_addr_o=RESET_PC.
//  States: IDLE -start_i-> RUN (PC<=start_addr_i, ir_valid<=0); RUN -HALT in ID, !stall-> HALTED;
//   HALTED -start_i-> RUN. start_i ignored in RUN. No fetch in IDLE/HALTED (ir_valid=0).
//  RUN, !stall_i: IR<=rom_data_i, pc_id<=PC, ir_valid<=1, PC<=PC+1 (8-bit wrap, 255->0).
//  stall_i=1: every register holds; outputs stay stable; no branch/halt action taken.
//  Decode (combinational from IR; inst_valid_o=ir_valid):
//   00dddsss AND / 01dddsss ADD: rd=ddd, rs=sss.
//   10000000 SLT, 10001000 HALT: rd=rs=0. Other 10000xxx/10001xxx -> ILL.
//   10010rrr LOAD, 10011 STORE, 10100 ABS, 10101 SEQ, 10110 BRB, 10111 -> ILL.
//   110iiiii SET: imm=iiiii, rd=rs=7. 11100 SLL, 11101 SRL, 11110 BR, 11111 SUB.
//   rrr formats: rd=rrr, rs=7, except BR/BRB: rs=rrr (offset register), rd=0. ILL: rd=rs=0.
//  Branch (ID, valid, !stall): taken iff flag_i=1. BR target=pc_id+1+reg_val_i;
//   BRB target=pc_id+1-reg_val_i; mod 256. Taken: PC<=target, ir_valid<=0 (squash
//   wrong-path byte) -> 1 bubble. Not taken: sequential, no bubble.
//  HALT (ID, valid, !stall): HALT shown on outputs that cycle; next edge state<=HALTED,
//   ir_valid<=0, PC holds at pc_id+1; halted_o=1 from that edge.
//  Latency: first instruction valid on decode outputs 1 cycle after start accepted.
//  ILL is issued like any instruction (datapath decides); fetch continues.
//  Reset mid-operation: immediate return to reset values, any in-flight IR discarded.
// TESTING
//  Reset then start_i, addr 0, ROM[0]=0xC1 -> next cycle valid, pc_id=0, SET imm=1 rd=rs=7.
//  ADD 0x4F at pc_id 5 -> op=1 rd=1 rs=7; ILL 0x87 and 0xB8 -> op=15, fetch continues.
//  BR 0xF7 at pc_id 17, flag=1, reg_val=6 -> one bubble, next valid pc_id=24; flag=0 -> 18, no bubble.
//  BRB 0xB7 at pc_id 126, flag=1, reg_val=25 -> next valid pc_id=102; at 255 with BR val 3 -> 3.
//  HALT 0x88 at 92 -> op=3 one cycle, then halted_o=1, valid=0, rom_addr_o=93 frozen; start_i,93 -> resumes.
//  stall_i 3 cycles mid-run -> outputs and rom_addr_o unchanged; rst_n_i low mid-branch -> IDLE, PC=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_decode.sv
// inst_fetch_decode: PC/ROM fetch stage plus IR decode stage with branch and halt resolution.
module inst_fetch_decode #(
   parameter logic [7:0] RESET_PC = 8'd0
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       start_i,
   input  logic [7:0] start_addr_i,
   input  logic       stall_i,
   output logic [7:0] rom_addr_o,
   input  logic [7:0] rom_data_i,
   input  logic       flag_i,
   input  logic [7:0] reg_val_i,
   output logic       inst_valid_o,
   output logic [7:0] pc_id_o,
   output logic [3:0] op_o,
   output logic [2:0] rd_o,
   output logic [2:0] rs_o,
   output logic [4:0] imm_o,
   output logic       halted_o
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;
   state_t     r_state, w_state_nx;
   logic [7:0] r_pc, r_ir, r_pc_id, w_pc_nx, w_ir_nx, w_pc_id_nx, w_target;
   logic       r_valid, w_valid_nx, w_taken;
   always_comb begin
      op_o  = 4'd15;
      rd_o  = 3'd0;
      rs_o  = 3'd0;
      imm_o = 5'd0;
      casez (r_ir)
         8'b00??????: begin op_o = 4'd0;  rd_o = r_ir[5:3]; rs_o = r_ir[2:0]; end
         8'b01??????: begin op_o = 4'd1;  rd_o = r_ir[5:3]; rs_o = r_ir[2:0]; end
         8'b10000000:       op_o = 4'd2;
         8'b10001000:       op_o = 4'd3;
         8'b10010???: begin op_o = 4'd4;  rd_o = r_ir[2:0]; rs_o = 3'd7; end
         8'b10011???: begin op_o = 4'd5;  rd_o = r_ir[2:0]; rs_o = 3'd7; end
         8'b10100???: begin op_o = 4'd6;  rd_o = r_ir[2:0]; rs_o = 3'd7; end
         8'b10101???: begin op_o = 4'd7;  rd_o = r_ir[2:0]; rs_o = 3'd7; end
         8'b10110???: begin op_o = 4'd8;  rs_o = r_ir[2:0]; end
         8'b110?????: begin op_o = 4'd9;  rd_o = 3'd7; rs_o = 3'd7; imm_o = r_ir[4:0]; end
         8'b11100???: begin op_o = 4'd10; rd_o = r_ir[2:0]; rs_o = 3'd7; end
         8'b11101???: begin op_o = 4'd11; rd_o = r_ir[2:0]; rs_o = 3'd7; end
         8'b11110???: begin op_o = 4'd12; rs_o = r_ir[2:0]; end
         8'b11111???: begin op_o = 4'd13; rd_o = r_ir[2:0]; rs_o = 3'd7; end
         default:           op_o = 4'd15;
      endcase
   end
   assign w_taken  = r_valid && flag_i && (op_o == 4'd12 || op_o == 4'd8);
   assign w_target = (op_o == 4'd12) ? r_pc_id + 8'd1 + reg_val_i : r_pc_id + 8'd1 - reg_val_i;
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_ir_nx    = r_ir;
      w_pc_id_nx = r_pc_id;
      w_valid_nx = r_valid;
      if (!stall_i) begin
         if (r_state != S_RUN) begin
            if (start_i) begin
               w_state_nx = S_RUN;
               w_pc_nx    = start_addr_i;
               w_valid_nx = 1'b0;
            end
         end else if (r_valid && op_o == 4'd3) begin
            w_state_nx = S_HALTED;
            w_valid_nx = 1'b0;
         end else if (w_taken) begin
            // the byte fetched alongside the branch is on the wrong path
            w_pc_nx    = w_target;
            w_valid_nx = 1'b0;
         end else begin
            w_ir_nx    = rom_data_i;
            w_pc_id_nx = r_pc;
            w_valid_nx = 1'b1;
            w_pc_nx    = r_pc + 8'd1;
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_ir    <= 8'd0;
         r_pc_id <= 8'd0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         r_ir    <= w_ir_nx;
         r_pc_id <= w_pc_id_nx;
         r_valid <= w_valid_nx;
      end
   end
   assign rom_addr_o   = r_pc;
   assign inst_valid_o = r_valid;
   assign pc_id_o      = r_pc_id;
   assign halted_o     = (r_state == S_HALTED);
endmodule

// File: tb/tb_inst_fetch_decode.sv
// tb_inst_fetch_decode: decode vector table, directed branch/halt/stall/reset sequences, random run vs model.
module tb_inst_fetch_decode;
   logic       clk_i = 1'b0, rst_n_i, start_i, stall_i, flag_i;
   logic [7:0] start_addr_i, rom_addr_o, rom_data_i, reg_val_i, pc_id_o;
   logic       inst_valid_o, halted_o;
   logic [3:0] op_o;
   logic [2:0] rd_o, rs_o;
   logic [4:0] imm_o;
   logic [7:0] rom [256];
   int         total = 0, bad = 0;
   // model: run state (0 idle, 1 run, 2 halted), pc, ir, pc of ir, ir valid
   int         m_st;
   logic [7:0] m_pc, m_ir, m_pcid;
   logic       m_v;

   inst_fetch_decode dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .start_addr_i(start_addr_i),
      .stall_i(stall_i), .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .flag_i(flag_i),
      .reg_val_i(reg_val_i), .inst_valid_o(inst_valid_o), .pc_id_o(pc_id_o), .op_o(op_o),
      .rd_o(rd_o), .rs_o(rs_o), .imm_o(imm_o), .halted_o(halted_o)
   );

   assign rom_data_i = rom[rom_addr_o];
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] b;
      logic [3:0] op;
      logic [2:0] rd, rs;
      logic [4:0] imm;
   } vec_t;
   vec_t vt[16];

   // returns {op, rd, rs, imm} from the instruction-set table
   function automatic logic [14:0] ref_dec(input logic [7:0] b);
      int v, g, r;
      int op, rd, rs, imm;
      v = b; g = (v / 8) % 8; r = v % 8;
      op = 15; rd = 0; rs = 0; imm = 0;
      if (v < 128) begin
         op = v / 64; rd = g; rs = r;
      end else if (v < 192) begin
         if (v == 128) op = 2;
         else if (v == 136) op = 3;
         else if (g >= 2 && g <= 5) begin op = g + 2; rd = r; rs = 7; end
         else if (g == 6) begin op = 8; rs = r; end
      end else if (v < 224) begin
         op = 9; rd = 7; rs = 7; imm = v % 32;
      end else begin
         op = 10 + (g % 4) + ((g % 4) == 3 ? 0 : 0);
         if (g % 4 == 3) op = 13;
         if (g % 4 == 2) rs = r; else begin rd = r; rs = 7; end
      end
      return {op[3:0], rd[2:0], rs[2:0], imm[4:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_model;
      chk("valid", {31'd0, inst_valid_o}, {31'd0, m_v});
      chk("rom_addr", {24'd0, rom_addr_o}, {24'd0, m_pc});
      chk("halted", {31'd0, halted_o}, {31'd0, m_st == 2});
      if (m_v) begin
         chk("pc_id", {24'd0, pc_id_o}, {24'd0, m_pcid});
         chk("decode", {17'd0, op_o, rd_o, rs_o, imm_o}, {17'd0, ref_dec(m_ir)});
      end
   endtask

   task automatic step;
      logic [14:0] d;
      int          op, tgt;
      d = ref_dec(m_ir);
      op = d[14:11];
      if (!stall_i) begin
         if (m_st != 1) begin
            if (start_i) begin m_st = 1; m_pc = start_addr_i; m_v = 0; end
         end else if (m_v && op == 3) begin
            m_st = 2; m_v = 0;
         end else if (m_v && flag_i && (op == 12 || op == 8)) begin
            tgt = (op == 12) ? m_pcid + 1 + reg_val_i : m_pcid + 1 - reg_val_i + 256;
            m_pc = tgt % 256; m_v = 0;
         end else begin
            m_ir = rom[m_pc]; m_pcid = m_pc; m_v = 1; m_pc = m_pc + 8'd1;
         end
      end
      @(posedge clk_i);
      #1;
      check_model();
   endtask

   task automatic do_reset;
      rst_n_i = 1'b0;
      start_i = 0; stall_i = 0; flag_i = 0; reg_val_i = 0; start_addr_i = 0;
      m_st = 0; m_pc = 8'd0; m_ir = 8'd0; m_pcid = 8'd0; m_v = 0;
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   task automatic start_at(input logic [7:0] a);
      start_i = 1; start_addr_i = a;
      step();
      start_i = 0;
   endtask

   initial begin
      logic [7:0] s_addr, s_pcid;
      logic [14:0] s_dec;
      vt[0]  = '{8'hC1, 4'd9, 3'd7, 3'd7, 5'd1};
      vt[1]  = '{8'h4F, 4'd1, 3'd1, 3'd7, 5'd0};
      vt[2]  = '{8'h87, 4'd15, 3'd0, 3'd0, 5'd0};
      vt[3]  = '{8'hB8, 4'd15, 3'd0, 3'd0, 5'd0};
      vt[4]  = '{8'h80, 4'd2, 3'd0, 3'd0, 5'd0};
      vt[5]  = '{8'h88, 4'd3, 3'd0, 3'd0, 5'd0};
      vt[6]  = '{8'h93, 4'd4, 3'd3, 3'd7, 5'd0};
      vt[7]  = '{8'h9D, 4'd5, 3'd5, 3'd7, 5'd0};
      vt[8]  = '{8'hA2, 4'd6, 3'd2, 3'd7, 5'd0};
      vt[9]  = '{8'hAE, 4'd7, 3'd6, 3'd7, 5'd0};
      vt[10] = '{8'hB7, 4'd8, 3'd0, 3'd7, 5'd0};
      vt[11] = '{8'hE4, 4'd10, 3'd4, 3'd7, 5'd0};
      vt[12] = '{8'hE9, 4'd11, 3'd1, 3'd7, 5'd0};
      vt[13] = '{8'hF7, 4'd12, 3'd0, 3'd7, 5'd0};
      vt[14] = '{8'hFA, 4'd13, 3'd2, 3'd7, 5'd0};
      vt[15] = '{8'h2C, 4'd0, 3'd5, 3'd4, 5'd0};
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      do_reset();
      chk("reset_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("reset_rom_addr", {24'd0, rom_addr_o}, 32'd0);
      chk("reset_halted", {31'd0, halted_o}, 32'd0);
      chk("reset_outs", {9'd0, pc_id_o, op_o, rd_o, rs_o, imm_o}, 32'd0);
      rom[0] = 8'hC1;
      start_at(8'd0);
      step();
      chk("first_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("first_pc_id", {24'd0, pc_id_o}, 32'd0);
      chk("first_set", {17'd0, op_o, rd_o, rs_o, imm_o}, {17'd0, 4'd9, 3'd7, 3'd7, 5'd1});
      for (int i = 0; i < 16; i++) begin
         do_reset();
         rom[5] = vt[i].b;
         start_at(8'd5);
         step();
         chk($sformatf("vec%0d_valid", i), {31'd0, inst_valid_o}, 32'd1);
         chk($sformatf("vec%0d_pc_id", i), {24'd0, pc_id_o}, 32'd5);
         chk($sformatf("vec%0d_dec", i), {17'd0, op_o, rd_o, rs_o, imm_o},
             {17'd0, vt[i].op, vt[i].rd, vt[i].rs, vt[i].imm});
         step();
         chk($sformatf("vec%0d_next", i), {24'd0, pc_id_o}, vt[i].b == 8'h88 ? 32'd5 : 32'd6);
      end
      for (int i = 0; i < 256; i++) rom[i] = 8'h00;
      rom[17] = 8'hF7; rom[126] = 8'hB7; rom[255] = 8'hF7; rom[92] = 8'h88;
      // BR taken at 17 and not taken
      do_reset(); start_at(8'd17); step();
      flag_i = 1; reg_val_i = 8'd6; step(); flag_i = 0;
      chk("br_bubble", {31'd0, inst_valid_o}, 32'd0);
      step();
      chk("br_target", {24'd0, pc_id_o}, 32'd24);
      do_reset(); start_at(8'd17); step();
      flag_i = 0; reg_val_i = 8'd6; step();
      chk("br_nt_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("br_nt_pc", {24'd0, pc_id_o}, 32'd18);
      do_reset(); start_at(8'd126); step();
      flag_i = 1; reg_val_i = 8'd25; step(); flag_i = 0; step();
      chk("brb_target", {24'd0, pc_id_o}, 32'd102);
      do_reset(); start_at(8'd255); step();
      flag_i = 1; reg_val_i = 8'd3; step(); flag_i = 0; step();
      chk("br_wrap", {24'd0, pc_id_o}, 32'd3);
      // halt and resume
      do_reset(); start_at(8'd92); step();
      chk("halt_op", {28'd0, op_o}, 32'd3);
      step(); step();
      chk("halt_flag", {31'd0, halted_o}, 32'd1);
      chk("halt_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("halt_addr", {24'd0, rom_addr_o}, 32'd93);
      start_at(8'd93);
      chk("resume_halted", {31'd0, halted_o}, 32'd0);
      step();
      chk("resume_pc", {24'd0, pc_id_o}, 32'd93);
      // stall holds everything
      do_reset(); start_at(8'd40); step(); step();
      s_addr = rom_addr_o; s_pcid = pc_id_o; s_dec = {op_o, rd_o, rs_o, imm_o};
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_addr", {24'd0, rom_addr_o}, {24'd0, s_addr});
         chk("stall_pc_id", {24'd0, pc_id_o}, {24'd0, s_pcid});
         chk("stall_dec", {17'd0, op_o, rd_o, rs_o, imm_o}, {17'd0, s_dec});
      end
      stall_i = 0; step();
      // async reset while a taken branch sits in ID
      do_reset(); start_at(8'd17); step();
      flag_i = 1; reg_val_i = 8'd6;
      #2 rst_n_i = 1'b0;
      #1;
      chk("rst_mid_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("rst_mid_addr", {24'd0, rom_addr_o}, 32'd0);
      chk("rst_mid_outs", {9'd0, pc_id_o, op_o, rd_o, rs_o, imm_o}, 32'd0);
      // random program and stimulus
      for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         stall_i = ($urandom_range(0, 4) == 0);
         flag_i = 1'($urandom);
         reg_val_i = 8'($urandom);
         start_i = ($urandom_range(0, 7) == 0);
         start_addr_i = 8'($urandom);
         step();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
